apb_uart_fifo: RTL and testbench
================================

Name: apb_uart_fifo

Overview:
APB-attached UART, parametrised successor to the fixed 8-bit single-buffer APB UART core. Adds runtime 16-bit baud divisor, configurable data width and TX/RX FIFOs. Adds sticky error status and a level interrupt. Sits on the peripheral APB bus and drives the board TX/RX pins.

Parameters:
DATA_W, 8, serial data bits per frame (5..8); upper PWDATA bits ignored, upper PRDATA data bits read 0
FIFO_DEPTH, 8, entries per TX and RX FIFO (power of 2, >=2)
DEFAULT_DIV, 16'd26, baud divisor reset value

Ports:
PCLK  in  1  clock
PRESETN  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write
PADDR  in  3  register address
PWDATA  in  8  write data
PRDATA  out  8  read data
PREADY  out  1  always 1 (zero wait states)
PSLVERR  out  1  error response
RX  in  1  serial input, idle high
TX  out  1  serial output, idle high
TXRDY  out  1  TX FIFO not full
RXRDY  out  1  RX FIFO not empty
IRQ  out  1  interrupt, level

Behaviour:
- Reset: TX=1, PRDATA=0, PSLVERR=0, FIFOs empty, TXRDY=1, RXRDY=0, IRQ=0, CTRL=0, STATUS sticky bits=0, divisor=DEFAULT_DIV. Reset mid-frame aborts the frame; TX returns to 1 immediately.
- Access = PSEL&PENABLE. Register map:
  - 0 DATA: write pushes TX FIFO. Read pops RX FIFO.
  - 1 STATUS: bit0 txfull, bit1 txempty, bit2 rxempty, bit3 rxfull, bit4 overrun, bit5 framing, bit6 parity. Writing 1 to bits 4-6 clears them.
  - 2 DIV_LO, 3 DIV_HI: 16-bit divisor.
  - 4 CTRL: bit0 txen, bit1 rxen, bit2 rxie, bit3 errie, bit4 paren, bit5 odd.
  - Addresses 5-7: PSLVERR=1, read 0, write ignored.
- PRDATA and PSLVERR are combinational during the access phase. DATA read pops on the access cycle.
- DATA write with TX full: PSLVERR=1, data dropped. DATA read with RX empty: PSLVERR=1, returns 0, no pop.
- Baud tick: counter 0..DIV, 1-cycle tick at DIV, so tick period = DIV+1 PCLK cycles. Bit period = 16 ticks. Writing DIV_LO or DIV_HI clears the counter.
- TX FSM IDLE->START->DATA(DATA_W bits, LSB first)->[PARITY]->STOP->IDLE, 16 ticks per state.
  - Leaves IDLE when txen=1 and FIFO non-empty; pops on entering START.
  - Clearing txen mid-frame finishes the current frame.
- RX input passes a 2-flop synchroniser. RX FSM IDLE->START->DATA->[PARITY]->STOP.
  - Falling edge in IDLE with rxen=1 starts the tick count. RX still low at tick 8 confirms START, else back to IDLE (glitch reject).
  - Data, parity and stop are sampled at tick 8 of each bit.
  - Stop=0 sets framing; the byte is still pushed.
  - RX FIFO full at stop: byte dropped, overrun set.
- FIFOs: simultaneous push+pop on a full or empty FIFO is legal; count is unchanged when both occur on a non-empty, non-full FIFO. Pointers wrap modulo FIFO_DEPTH.
- IRQ = (rxie & RXRDY) | (errie & (overrun|framing|parity)).

Optional Feature:
UART_PARITY_EN
- Defined: CTRL bit4 enables a parity bit after the data bits, even by default, odd when bit5=1. TX generates it; RX checks it and sets the parity sticky bit on mismatch, byte still pushed.
- Undefined: no parity state. CTRL bits 4-5 read 0 and writes are ignored. STATUS bit6 reads 0.

Test Plan:
- Reset, read STATUS -> 0x06. Read DIV_LO/HI -> 0x1A/0x00. TX=1, TXRDY=1, RXRDY=0.
- DIV=1, CTRL=0x01, write DATA=0x9A, PCLK period 32 ns -> TX low for 1024 ns, then bits 0,1,0,1,1,0,0,1, each 1024 ns, then stop high. STATUS txempty=1 after the frame.
- DIV=1, rxen=1, drive 0x9A LSB-first on RX at 1024 ns/bit -> RXRDY=1. DATA read returns 0x9A, then RXRDY=0.
- Write FIFO_DEPTH+1 bytes with txen=0 -> TXRDY=0 after the 8th write. 9th write gives PSLVERR=1. Read STATUS -> txfull=1.
- Receive 9 frames without reading -> overrun=1, IRQ=1 (errie=1). Write STATUS=0x10 -> overrun=0. Reading returns the first 8 bytes in order.
- Stop bit driven 0 -> framing=1. Parity build with even parity and a wrong parity bit -> parity=1. 300 ns RX glitch -> no byte received.

Source files
------------

// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB slave UART with a runtime 16-bit baud divisor, configurable frame width,
// TX/RX FIFOs, sticky error status and a level interrupt.
// Optional feature macro: UART_PARITY_EN (parity generation/checking, CTRL bits 4-5).
// Ports:
//   PCLK, PRESETN        clock, asynchronous active-low reset
//   PSEL, PENABLE,       APB slave: select, access phase, direction, address, write data
//   PWRITE, PADDR,
//   PWDATA
//   PRDATA, PREADY,      APB slave: read data, ready (always 1), error response
//   PSLVERR
//   RX, TX               serial input / output, both idle high
//   TXRDY, RXRDY         TX FIFO not full, RX FIFO not empty
//   IRQ                  level interrupt
module apb_uart_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd26
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [2:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       RX,
  output logic       TX,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic       IRQ
);

  localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW        = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_W - 1);
`ifdef UART_PARITY_EN
  localparam logic [5:0]    CTRL_MASK = 6'h3f;
`else
  localparam logic [5:0]    CTRL_MASK = 6'h0f;
`endif

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop
  } rx_state_e;

  // Configuration and status
  logic [5:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d, frm_q, frm_d, par_q, par_d;
  logic        ovr_set, frm_set;
  logic        txen, rxen, rxie, errie;
`ifdef UART_PARITY_EN
  logic        paren, odd, par_set;
  assign paren = ctrl_q[4];
  assign odd   = ctrl_q[5];
`endif
  assign txen  = ctrl_q[0];
  assign rxen  = ctrl_q[1];
  assign rxie  = ctrl_q[2];
  assign errie = ctrl_q[3];

  // APB decode
  logic access, wr_en, rd_en, stat_clr;
  logic sel_data, sel_stat, sel_divlo, sel_divhi, sel_ctrl, sel_bad;
  assign access    = PSEL & PENABLE;
  assign wr_en     = access & PWRITE;
  assign rd_en     = access & ~PWRITE;
  assign sel_data  = (PADDR == 3'd0);
  assign sel_stat  = (PADDR == 3'd1);
  assign sel_divlo = (PADDR == 3'd2);
  assign sel_divhi = (PADDR == 3'd3);
  assign sel_ctrl  = (PADDR == 3'd4);
  assign sel_bad   = (PADDR > 3'd4);
  assign stat_clr  = wr_en & sel_stat;

  // FIFOs
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_push  = wr_en & sel_data & ~tx_full;
  assign rx_pop   = rd_en & sel_data & ~rx_empty;

  // Baud generator
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        tick, div_wr;
  assign tick   = (baud_cnt_q == div_q);
  assign div_wr = wr_en & (sel_divlo | sel_divhi);

  // RX synchroniser; third stage is only for falling-edge detection
  logic rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // TX FSM state
  tx_state_e         tx_state_q, tx_state_d;
  logic [3:0]        tx_tcnt_q, tx_tcnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_bit_end;
`ifdef UART_PARITY_EN
  logic              tx_par_q, tx_par_d;
`endif

  // RX FSM state
  rx_state_e         rx_state_q, rx_state_d;
  logic [3:0]        rx_tcnt_q, rx_tcnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_mid, rx_bit_end;

  logic [7:0] status, rd_data_ext;
  assign status = {1'b0, par_q, frm_q, ovr_q, rx_full, rx_empty, tx_empty, tx_full};

  // APB read path and error response, combinational during the access phase
  always_comb begin
    rd_data_ext               = '0;
    rd_data_ext[DATA_W-1:0]   = rx_mem[rx_rd_q];
    PRDATA                    = '0;
    if (rd_en) begin
      case (PADDR)
        3'd0:    PRDATA = rx_empty ? 8'h00 : rd_data_ext;
        3'd1:    PRDATA = status;
        3'd2:    PRDATA = div_q[7:0];
        3'd3:    PRDATA = div_q[15:8];
        3'd4:    PRDATA = {2'b00, ctrl_q};
        default: PRDATA = '0;
      endcase
    end
    PSLVERR = access & (sel_bad | (sel_data & PWRITE & tx_full) |
                        (sel_data & ~PWRITE & rx_empty));
  end

  // Register, sticky-bit, FIFO pointer and baud counter next state
  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    if (wr_en) begin
      if (sel_ctrl)  ctrl_d      = PWDATA[5:0] & CTRL_MASK;
      if (sel_divlo) div_d[7:0]  = PWDATA;
      if (sel_divhi) div_d[15:8] = PWDATA;
    end
    // A new error event wins over a simultaneous write-1-to-clear
    ovr_d = (ovr_q & ~(stat_clr & PWDATA[4])) | ovr_set;
    frm_d = (frm_q & ~(stat_clr & PWDATA[5])) | frm_set;
`ifdef UART_PARITY_EN
    par_d = (par_q & ~(stat_clr & PWDATA[6])) | par_set;
`else
    par_d = 1'b0;
`endif
    tx_wr_d  = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wr_d  = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    if (div_wr || tick) baud_cnt_d = '0;
    else                baud_cnt_d = baud_cnt_q + 16'd1;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      ctrl_q     <= '0;
      div_q      <= DEFAULT_DIV;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      par_q      <= 1'b0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      baud_cnt_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      par_q      <= par_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the counters
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr_q] <= PWDATA[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  // TX FSM: state register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      tx_state_q <= TxIdle;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // TX FSM: next state. Frames start on a tick so every state lasts exactly 16 ticks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_bit_end = tick & (tx_tcnt_q == 4'd15);
    if ((tx_state_q != TxIdle) && tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_state_q)
      TxIdle: begin
        if (tx_pop) begin
          tx_state_d = TxStart;
          tx_tcnt_d  = '0;
          tx_shift_d = tx_mem[tx_rd_q];
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_mem[tx_rd_q]) ^ odd;
`endif
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_d = paren ? TxParity : TxStop;
`else
            tx_state_d = TxStop;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TxParity: if (tx_bit_end) tx_state_d = TxStop;
`endif
      TxStop:   if (tx_bit_end) tx_state_d = TxIdle;
      default:  tx_state_d = TxIdle;
    endcase
  end

  // TX FSM: outputs. txen is only consulted in idle, so clearing it finishes the frame.
  always_comb begin
    tx_pop = 1'b0;
    TX     = 1'b1;
    case (tx_state_q)
      TxIdle:   tx_pop = tick & txen & ~tx_empty;
      TxStart:  TX = 1'b0;
      TxData:   TX = tx_shift_q[0];
`ifdef UART_PARITY_EN
      TxParity: TX = tx_par_q;
`endif
      default:  TX = 1'b1;
    endcase
  end

  // RX FSM: state register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_state_q <= RxIdle;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX FSM: next state. Samples at tick 8 of each bit; returns to idle at the stop-bit
  // centre so the next start edge is never missed.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_mid     = tick & (rx_tcnt_q == 4'd7);
    rx_bit_end = tick & (rx_tcnt_q == 4'd15);
    if ((rx_state_q != RxIdle) && tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
    case (rx_state_q)
      RxIdle: begin
        if (rxen && rx_fall) begin
          rx_state_d = RxStart;
          rx_tcnt_d  = '0;
        end
      end
      RxStart: begin
        if (rx_mid && rx_s2_q) begin
          rx_state_d = RxIdle;  // glitch: line high again at the start-bit centre
        end else if (rx_bit_end) begin
          rx_state_d = RxData;
          rx_bit_d   = '0;
        end
      end
      RxData: begin
        if (rx_mid) rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
        if (rx_bit_end) begin
          if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_d = paren ? RxParity : RxStop;
`else
            rx_state_d = RxStop;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RxParity: if (rx_bit_end) rx_state_d = RxStop;
`endif
      RxStop:   if (rx_mid) rx_state_d = RxIdle;
      default:  rx_state_d = RxIdle;
    endcase
  end

  // RX FSM: outputs (FIFO push and error events)
  always_comb begin
    rx_push = 1'b0;
    ovr_set = 1'b0;
    frm_set = 1'b0;
`ifdef UART_PARITY_EN
    par_set = 1'b0;
`endif
    case (rx_state_q)
`ifdef UART_PARITY_EN
      RxParity: par_set = rx_mid & (rx_s2_q != ((^rx_shift_q) ^ odd));
`endif
      RxStop: begin
        if (rx_mid) begin
          rx_push = ~rx_full;
          ovr_set = rx_full;
          frm_set = ~rx_s2_q;
        end
      end
      default: ;
    endcase
  end

  assign PREADY = 1'b1;
  assign TXRDY  = ~tx_full;
  assign RXRDY  = ~rx_empty;
  assign IRQ    = (rxie & ~rx_empty) | (errie & (ovr_q | frm_q | par_q));

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Self-checking bench for apb_uart_fifo: randomized bytes against a queue-based model of the
// UART (FIFO contents, sticky errors) and a bit-level decoder/driver on the serial pins.
module tb_apb_uart_fifo;

  localparam int DEPTH = 8;
  localparam int BIT_T = 1024;  // 16 ticks * (DIV+1=2) * 32-unit clock

  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [2:0] PADDR = 3'd0;
  logic [7:0] PWDATA = 8'h00;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;
  logic       RX = 1'b1;
  logic       TX, TXRDY, RXRDY, IRQ;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] rx_q[$];
  logic       m_ovr = 1'b0, m_frm = 1'b0, m_par = 1'b0;

  apb_uart_fifo dut (
    .PCLK   (PCLK),
    .PRESETN(PRESETN),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .RX     (RX),
    .TX     (TX),
    .TXRDY  (TXRDY),
    .RXRDY  (RXRDY),
    .IRQ    (IRQ)
  );

  always #16 PCLK = ~PCLK;

  function automatic logic [7:0] exp_status(input int tx_level);
    exp_status = {1'b0, m_par, m_frm, m_ovr, rx_q.size() == DEPTH, rx_q.size() == 0,
                  tx_level == 0, tx_level == DEPTH};
  endfunction

  task automatic apb_wr(input logic [2:0] a, input logic [7:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [2:0] a, output logic [7:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d   = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Drive one frame on RX and update the model with what the UART should make of it
  task automatic rx_send(input logic [7:0] d, input logic stop, input logic use_par,
                         input logic par_bit, input logic par_good);
    RX = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      #(BIT_T);
    end
    if (use_par) begin
      RX = par_bit;
      #(BIT_T);
    end
    RX = stop;
    #(BIT_T);
    RX = 1'b1;
    #(BIT_T / 4);
    if (!stop) m_frm = 1'b1;
    if (!par_good) m_par = 1'b1;
    if (rx_q.size() == DEPTH) m_ovr = 1'b1;
    else rx_q.push_back(d);
  endtask

  // Decode one frame seen on TX, sampling at bit centres after the start edge
  task automatic tx_decode(input logic with_par, output logic [7:0] b, output logic start_ok,
                           output logic stop_ok, output logic found, output logic p);
    found = 1'b0; start_ok = 1'b0; stop_ok = 1'b0; b = 8'h00; p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge PCLK);
      if (TX === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      repeat (16) @(negedge PCLK);
      start_ok = (TX === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (32) @(negedge PCLK);
        b[i] = TX;
      end
      if (with_par) begin
        repeat (32) @(negedge PCLK);
        p = TX;
      end
      repeat (32) @(negedge PCLK);
      stop_ok = (TX === 1'b1);
    end
  endtask

  task automatic set_div1();
    logic e;
    apb_wr(3'd2, 8'h01, e);
    apb_wr(3'd3, 8'h00, e);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       e;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", TX); end
    checks++; if (TXRDY !== 1'b1 || RXRDY !== 1'b0 || IRQ !== 1'b0) begin
      errors++; $display("FAIL reset_flags: txrdy=%b rxrdy=%b irq=%b want 1 0 0", TXRDY, RXRDY, IRQ);
    end
    checks++; if (PRDATA !== 8'h00 || PSLVERR !== 1'b0 || PREADY !== 1'b1) begin
      errors++; $display("FAIL reset_apb: prdata=%h pslverr=%b pready=%b want 00 0 1",
                         PRDATA, PSLVERR, PREADY);
    end
    apb_rd(3'd1, d, e);
    checks++; if (d !== 8'h06 || e !== 1'b0) begin
      errors++; $display("FAIL reset_status: got %h err %b want 06 0", d, e);
    end
    apb_rd(3'd2, d, e);
    checks++; if (d !== 8'h1a) begin errors++; $display("FAIL reset_divlo: got %h want 1a", d); end
    apb_rd(3'd3, d, e);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_divhi: got %h want 00", d); end
    apb_rd(3'd4, d, e);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", d); end
  endtask

  task automatic test_regs();
    logic [7:0] d, lo, hi, c, mask;
    logic       e;
`ifdef UART_PARITY_EN
    mask = 8'h3f;
`else
    mask = 8'h0f;
`endif
    for (int i = 0; i < 3; i++) begin
      lo = 8'($urandom); hi = 8'($urandom); c = 8'($urandom) & 8'hf0;
      apb_wr(3'd2, lo, e);
      apb_wr(3'd3, hi, e);
      apb_wr(3'd4, c, e);  // low bits clear: no txen/rxen activity
      apb_rd(3'd2, d, e);
      checks++; if (d !== lo) begin errors++; $display("FAIL regs_divlo: got %h want %h", d, lo); end
      apb_rd(3'd3, d, e);
      checks++; if (d !== hi) begin errors++; $display("FAIL regs_divhi: got %h want %h", d, hi); end
      apb_rd(3'd4, d, e);
      checks++; if (d !== (c & mask)) begin
        errors++; $display("FAIL regs_ctrl: got %h want %h", d, c & mask);
      end
    end
    apb_wr(3'd4, 8'h00, e);
    for (int a = 5; a < 8; a++) begin
      apb_wr(3'(a), 8'hff, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_wr_err: addr %0d got %b want 1", a, e); end
      apb_rd(3'(a), d, e);
      checks++; if (e !== 1'b1 || d !== 8'h00) begin
        errors++; $display("FAIL bad_rd: addr %0d data %h err %b want 00 1", a, d, e);
      end
    end
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0)) begin
      errors++; $display("FAIL regs_status: got %h want %h", d, exp_status(0));
    end
  endtask

  task automatic test_tx();
    logic [7:0] b, want, d;
    logic       e, s0, s1, f, p;
    set_div1();
    apb_wr(3'd4, 8'h01, e);
    for (int i = 0; i < 4; i++) begin
      want = (i == 0) ? 8'h9a : 8'($urandom);
      apb_wr(3'd0, want, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL tx_wr_err: got %b want 0", e); end
      tx_decode(1'b0, b, s0, s1, f, p);
      checks++; if (!f || !s0 || !s1 || b !== want) begin
        errors++; $display("FAIL tx_frame: byte %h found %b start %b stop %b want %h 1 1 1",
                           b, f, s0, s1, want);
      end
    end
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0)) begin
      errors++; $display("FAIL tx_status: got %h want %h", d, exp_status(0));
    end
  endtask

  task automatic test_rx();
    logic [7:0] v, d;
    logic       e;
    apb_wr(3'd4, 8'h02, e);
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 8'h9a : 8'($urandom);
      rx_send(v, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++; if (RXRDY !== 1'b1) begin errors++; $display("FAIL rx_rdy: got %b want 1", RXRDY); end
      apb_rd(3'd0, d, e);
      v = rx_q.pop_front();
      checks++; if (d !== v || e !== 1'b0) begin
        errors++; $display("FAIL rx_data: got %h err %b want %h 0", d, e, v);
      end
      checks++; if (RXRDY !== 1'b0) begin errors++; $display("FAIL rx_rdy_clr: got %b want 0", RXRDY); end
    end
    apb_rd(3'd0, d, e);
    checks++; if (d !== 8'h00 || e !== 1'b1) begin
      errors++; $display("FAIL rx_empty_rd: got %h err %b want 00 1", d, e);
    end
    apb_wr(3'd4, 8'h06, e);  // rxie
    v = 8'($urandom);
    rx_send(v, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b want 1", IRQ); end
    apb_rd(3'd0, d, e);
    v = rx_q.pop_front();
    checks++; if (d !== v || IRQ !== 1'b0) begin
      errors++; $display("FAIL rx_irq_data: got %h irq %b want %h 0", d, IRQ, v);
    end
  endtask

  task automatic test_tx_fifo_full();
    logic [7:0] q[$];
    logic [7:0] v, b, d;
    logic       e, s0, s1, f, p;
    apb_wr(3'd4, 8'h00, e);
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      q.push_back(v);
      apb_wr(3'd0, v, e);
      checks++; if (TXRDY !== (i < DEPTH - 1) || e !== 1'b0) begin
        errors++; $display("FAIL txfull_rdy: write %0d txrdy %b err %b want %b 0", i, TXRDY, e,
                           i < DEPTH - 1);
      end
    end
    apb_wr(3'd0, 8'h55, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL txfull_err: got %b want 1", e); end
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(DEPTH)) begin
      errors++; $display("FAIL txfull_status: got %h want %h", d, exp_status(DEPTH));
    end
    apb_wr(3'd4, 8'h01, e);
    for (int i = 0; i < DEPTH; i++) begin
      tx_decode(1'b0, b, s0, s1, f, p);
      v = q.pop_front();
      checks++; if (!f || !s0 || !s1 || b !== v) begin
        errors++; $display("FAIL b2b_frame: %0d byte %h found %b start %b stop %b want %h",
                           i, b, f, s0, s1, v);
      end
    end
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0)) begin
      errors++; $display("FAIL b2b_status: got %h want %h", d, exp_status(0));
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d, v;
    logic       e;
    apb_wr(3'd4, 8'h0a, e);  // rxen, errie
    for (int i = 0; i < DEPTH + 1; i++) rx_send(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0)) begin
      errors++; $display("FAIL ovr_status: got %h want %h", d, exp_status(0));
    end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b want 1", IRQ); end
    apb_wr(3'd1, 8'h10, e);
    m_ovr = 1'b0;
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0) || IRQ !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: status %h irq %b want %h 0", d, IRQ, exp_status(0));
    end
    for (int i = 0; i < DEPTH; i++) begin
      apb_rd(3'd0, d, e);
      v = rx_q.pop_front();
      checks++; if (d !== v || e !== 1'b0) begin
        errors++; $display("FAIL ovr_data: %0d got %h err %b want %h 0", i, d, e, v);
      end
    end
    checks++; if (RXRDY !== 1'b0) begin errors++; $display("FAIL ovr_drain: rxrdy %b want 0", RXRDY); end
  endtask

  task automatic test_framing();
    logic [7:0] d, v;
    logic       e;
    rx_send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0) || IRQ !== 1'b1) begin
      errors++; $display("FAIL frm_status: status %h irq %b want %h 1", d, IRQ, exp_status(0));
    end
    apb_rd(3'd0, d, e);
    v = rx_q.pop_front();
    checks++; if (d !== v) begin errors++; $display("FAIL frm_data: got %h want %h", d, v); end
    apb_wr(3'd1, 8'h20, e);
    m_frm = 1'b0;
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0) || IRQ !== 1'b0) begin
      errors++; $display("FAIL frm_clear: status %h irq %b want %h 0", d, IRQ, exp_status(0));
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d, v;
    logic       e;
    apb_wr(3'd4, 8'h02, e);
    RX = 1'b0;
    #300;
    RX = 1'b1;
    #(3 * BIT_T);
    checks++; if (RXRDY !== 1'b0) begin errors++; $display("FAIL glitch_rx: rxrdy %b want 0", RXRDY); end
    v = 8'($urandom);
    rx_send(v, 1'b1, 1'b0, 1'b0, 1'b1);
    apb_rd(3'd0, d, e);
    v = rx_q.pop_front();
    checks++; if (d !== v || e !== 1'b0) begin
      errors++; $display("FAIL glitch_recover: got %h err %b want %h 0", d, e, v);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [7:0] d, v, b;
    logic       e, s0, s1, f, p;
    apb_wr(3'd4, 8'h12, e);  // rxen, even parity
    v = 8'($urandom);
    rx_send(v, 1'b1, 1'b1, ^v, 1'b1);
    v = 8'($urandom);
    rx_send(v, 1'b1, 1'b1, ~(^v), 1'b0);
    apb_rd(3'd1, d, e);
    checks++; if (d !== exp_status(0)) begin
      errors++; $display("FAIL par_status: got %h want %h", d, exp_status(0));
    end
    for (int i = 0; i < 2; i++) begin
      apb_rd(3'd0, d, e);
      v = rx_q.pop_front();
      checks++; if (d !== v) begin errors++; $display("FAIL par_data: got %h want %h", d, v); end
    end
    apb_wr(3'd1, 8'h40, e);
    m_par = 1'b0;
    apb_wr(3'd4, 8'h31, e);  // txen, odd parity
    v = 8'($urandom);
    apb_wr(3'd0, v, e);
    tx_decode(1'b1, b, s0, s1, f, p);
    checks++; if (!f || !s1 || b !== v || p !== ~(^v)) begin
      errors++; $display("FAIL par_tx: byte %h par %b stop %b want %h %b 1", b, p, s1, v, ~(^v));
    end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic       e, f;
    apb_wr(3'd4, 8'h01, e);
    apb_wr(3'd0, 8'h00, e);
    f = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge PCLK);
      if (TX === 1'b0) begin
        f = 1'b1;
        break;
      end
    end
    checks++; if (!f) begin errors++; $display("FAIL mid_start: tx never low, got %b want 1", f); end
    repeat (40) @(negedge PCLK);
    #3;
    PRESETN = 1'b0;
    #2;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b want 1", TX); end
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    apb_rd(3'd1, d, e);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL mid_status: got %h want 06", d); end
    apb_rd(3'd2, d, e);
    checks++; if (d !== 8'h1a) begin errors++; $display("FAIL mid_div: got %h want 1a", d); end
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETN = 1'b1;
    test_reset();
    test_regs();
    test_tx();
    test_rx();
    test_tx_fifo_full();
    test_overrun();
    test_framing();
    test_glitch();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
